// File: rtl/bias_update_sequencer_pkg.sv
// Shared definitions for the bias-update sequencer: FSM encoding, default
// network geometry and small elaboration-time helpers.
package bias_update_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_UPD  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int DEF_HIDDEN = 16;
  localparam int DEF_X      = 4;
  localparam int DEF_LAYER  = 3;

  function automatic int total_bias(input int layer, input int hidden, input int xo);
    return (layer - 1) * hidden + xo;
  endfunction

  localparam int TOTAL_BIAS = total_bias(DEF_LAYER, DEF_HIDDEN, DEF_X);

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bias_update_sequencer_index.sv
// Neuron/layer walker: output layer first, then downwards; neuron wraps at
// x in the output layer and HiddenNeuron elsewhere.
module bias_index_counter
  import bias_update_sequencer_pkg::*;
#(
  parameter int AWIDTH       = 10,
  parameter int HiddenNeuron = DEF_HIDDEN,
  parameter int x            = DEF_X,
  parameter int Layer        = DEF_LAYER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  output logic [AWIDTH-1:0] idx,
  output logic              last
);

  localparam int NMAX = (HiddenNeuron > x) ? HiddenNeuron : x;
  localparam int LW   = cw(Layer);
  localparam int NW   = cw(NMAX + 1);

  localparam logic [LW-1:0] TOP_L   = LW'(Layer - 1);
  // An empty output layer is skipped by starting one layer lower.
  localparam logic [LW-1:0] FIRST_L = (x == 0 && Layer > 1) ? LW'(Layer - 2) : LW'(Layer - 1);

  logic [LW-1:0] layer;
  logic [NW-1:0] neuron;
  logic [NW-1:0] wrap;
  logic          nlast;

  assign wrap  = (layer == TOP_L) ? NW'(x) : NW'(HiddenNeuron);
  assign nlast = (neuron == wrap - NW'(1));
  assign last  = (layer == '0) && nlast;
  assign idx   = AWIDTH'(layer) * AWIDTH'(HiddenNeuron) + AWIDTH'(neuron);

  always_ff @(posedge clk) begin
    if (!rst) begin
      layer  <= '0;
      neuron <= '0;
    end else if (load) begin
      layer  <= FIRST_L;
      neuron <= '0;
    end else if (adv) begin
      if (nlast) begin
        neuron <= '0;
        layer  <= layer - LW'(1);
      end else begin
        neuron <= neuron + NW'(1);
      end
    end
  end

endmodule

// File: rtl/bias_update_sequencer.sv
// Walks every bias through read -> latency wait -> datapath enable -> write
// back, between the training FSM handshake and the bias BRAM / delta buffer.
module bias_update_sequencer
  import bias_update_sequencer_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 10,
  parameter int HiddenNeuron = DEF_HIDDEN,
  parameter int x            = DEF_X,
  parameter int Layer        = DEF_LAYER,
  parameter int BIAS_BASE    = 0,
  parameter int RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [AWIDTH-1:0] bram_addr,
  output logic              bram_re,
  output logic              bram_we,
  output logic [AWIDTH-1:0] delta_addr,
  output logic              en_b_back,
  output logic              busy,
  output logic              done
);

  localparam int NBIAS = total_bias(Layer, HiddenNeuron, x);
  localparam int WCW   = cw(RD_LAT);

  if (RD_LAT < 1 || DWIDTH < 1) begin : g_bad_cfg
    $error("bias_update_sequencer: RD_LAT and DWIDTH must be >= 1");
  end

  state_t           state, nstate;
  logic [WCW-1:0]   wcnt;
  logic [AWIDTH-1:0] idx;
  logic             last;
  logic             ld, adv, act;

  assign ld  = (state == S_IDLE) && start && !hold;
  assign adv = (state == S_WR) && !hold;

  bias_index_counter #(
    .AWIDTH      (AWIDTH),
    .HiddenNeuron(HiddenNeuron),
    .x           (x),
    .Layer       (Layer)
  ) u_idx (
    .clk (clk),
    .rst (rst),
    .load(ld),
    .adv (adv),
    .idx (idx),
    .last(last)
  );

  // hold freezes state and wait count together so a held step resumes intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else if (!hold) begin
      state <= nstate;
      wcnt  <= (state == S_WAIT) ? wcnt + WCW'(1) : '0;
    end
  end

  // RD itself is the first latency cycle, so WAIT lasts RD_LAT-1 cycles.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (start) nstate = (NBIAS == 0) ? S_DONE : S_RD;
      S_RD:   nstate = (RD_LAT == 1) ? S_UPD : S_WAIT;
      S_WAIT: if (wcnt == WCW'(RD_LAT - 2)) nstate = S_UPD;
      S_UPD:  nstate = S_WR;
      S_WR:   nstate = last ? S_DONE : S_RD;
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Strobes also drop while rst is low so a write caught by reset never lands.
  assign act = rst && !hold;

  always_comb begin
    bram_re    = 1'b0;
    bram_we    = 1'b0;
    en_b_back  = 1'b0;
    bram_addr  = '0;
    delta_addr = '0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    case (state)
      S_RD:   bram_re   = act;
      S_UPD:  en_b_back = act;
      S_WR:   bram_we   = act;
      default: ;
    endcase
    if (state inside {S_RD, S_WAIT, S_UPD, S_WR}) begin
      bram_addr  = AWIDTH'(BIAS_BASE) + idx;
      delta_addr = idx;
    end
  end

endmodule

// File: tb/tb_bias_update_sequencer.sv
// Randomized self-checking bench: a default-geometry DUT driven through
// full passes, hold, mid-pass start and reset, plus a small RD_LAT=2 instance.
module tb_bias_update_sequencer;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, hold_a;
  logic [AW-1:0] a_addr, a_daddr;
  logic          a_re, a_we, a_en, a_busy, a_done;

  logic          rst_b, start_b, hold_b;
  logic [AW-1:0] b_addr, b_daddr;
  logic          b_re, b_we, b_en, b_busy, b_done;

  bias_update_sequencer dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .hold(hold_a),
    .bram_addr(a_addr), .bram_re(a_re), .bram_we(a_we), .delta_addr(a_daddr),
    .en_b_back(a_en), .busy(a_busy), .done(a_done)
  );

  bias_update_sequencer #(.RD_LAT(2), .Layer(1), .x(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .hold(hold_b),
    .bram_addr(b_addr), .bram_re(b_re), .bram_we(b_we), .delta_addr(b_daddr),
    .en_b_back(b_en), .busy(b_busy), .done(b_done)
  );

  // Datapath model: BRAM/delta with one-cycle read, new_bias = old + lr*delta.
  logic [31:0] mem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] init_mem [0:1023];
  logic [31:0] rdata, ddata, new_bias, lr;
  logic        do_init;

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] v;
        v = $urandom;
        mem[i]      <= v;
        init_mem[i] <= v;
        dmem[i]     <= $urandom;
      end
    end else begin
      if (a_re) begin
        rdata <= mem[a_addr];
        ddata <= dmem[a_daddr];
      end
      if (a_en) new_bias <= rdata + lr * ddata;
      if (a_we) mem[a_addr] <= new_bias;
    end
  end

  int checks = 0;
  int failures = 0;

  int exp_q[$];
  int we_addr_q[$], we_cyc_q[$], re_cyc_q[$], en_cyc_q[$], done_cyc_q[$];
  logic busy1, busy_after;
  logic [24:0] snap;
  logic we_at_rst;

  // Expected update order straight from the layer/neuron rules.
  task automatic build_order(input int layers, input int hn, input int xo, input int base);
    exp_q.delete();
    for (int l = layers - 1; l >= 0; l--) begin
      int nl;
      nl = (l == layers - 1) ? xo : hn;
      for (int n = 0; n < nl; n++) exp_q.push_back(base + l * hn + n);
    end
  endtask

  task automatic run_a(input int restart_at, input int hold_at, input int hold_len, input int rst_at);
    int c;
    we_addr_q.delete(); we_cyc_q.delete(); re_cyc_q.delete();
    en_cyc_q.delete(); done_cyc_q.delete();
    busy1 = 1'b0; busy_after = 1'b1; snap = '1; we_at_rst = 1'b1;
    @(posedge clk); #1 do_init = 1'b1;
    @(posedge clk); #1 do_init = 1'b0;
    c = 0;
    forever begin
      start_a = (c == 0) || (c == restart_at);
      hold_a  = (c >= hold_at) && (c < hold_at + hold_len);
      rst_a   = (c != rst_at);
      @(negedge clk);
      if (a_re) re_cyc_q.push_back(c);
      if (a_en) en_cyc_q.push_back(c);
      if (a_we) begin
        we_cyc_q.push_back(c);
        we_addr_q.push_back(int'(a_addr));
      end
      if (a_done) done_cyc_q.push_back(c);
      if (c == 1) busy1 = a_busy;
      if (c == rst_at) we_at_rst = a_we;
      if (c == rst_at + 1) snap = {a_addr, a_re, a_we, a_daddr, a_en, a_busy, a_done};
      if (done_cyc_q.size() > 0 && c == done_cyc_q[0] + 1) busy_after = a_busy;
      if ((done_cyc_q.size() > 0 && c >= done_cyc_q[0] + 2) ||
          (rst_at >= 0 && c >= rst_at + 2) || c >= 400) break;
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    start_a = 1'b0; hold_a = 1'b0; rst_a = 1'b1;
  endtask

  task automatic test_reset;
    rst_a = 1'b0; start_a = 1'b0; hold_a = 1'b0; do_init = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_addr, a_re, a_we, a_daddr, a_en, a_busy, a_done} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {a_addr, a_re, a_we, a_daddr, a_en, a_busy, a_done});
    end
    @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_re, b_busy} !== 4'd0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=0000", {a_busy, a_done, a_re, b_busy});
    end
  endtask

  task automatic test_full_pass;
    int n;
    lr = $urandom_range(1, 15);
    build_order(3, 16, 4, 0);
    run_a(-1, -100, 0, -1);
    n = exp_q.size();
    checks++;
    if (we_addr_q.size() != n) begin
      failures++;
      $display("FAIL pass_we_count got=%0d want=%0d", we_addr_q.size(), n);
    end
    for (int k = 0; k < n && k < we_addr_q.size(); k++) begin
      checks++;
      if (we_addr_q[k] != exp_q[k] || we_cyc_q[k] != 3 * k + 3 ||
          re_cyc_q[k] != 3 * k + 1 || en_cyc_q[k] != 3 * k + 2) begin
        failures++;
        $display("FAIL pass_bias%0d got addr=%0d re=%0d en=%0d we=%0d want addr=%0d re=%0d en=%0d we=%0d",
                 k, we_addr_q[k], re_cyc_q[k], en_cyc_q[k], we_cyc_q[k], exp_q[k], 3*k+1, 3*k+2, 3*k+3);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 109) begin
      failures++;
      $display("FAIL pass_done got pulses=%0d first=%0d want 1 pulse at 109",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL pass_busy got c1=%b after=%b want 1/0", busy1, busy_after);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (mem[exp_q[k]] !== init_mem[exp_q[k]] + lr * dmem[exp_q[k]]) begin
        failures++;
        $display("FAIL pass_data addr=%0d got=%h want=%h", exp_q[k], mem[exp_q[k]],
                 init_mem[exp_q[k]] + lr * dmem[exp_q[k]]);
      end
    end
  endtask

  task automatic test_hold;
    int k, u;
    lr = $urandom_range(1, 15);
    k = $urandom_range(0, 35);
    u = 3 * k + 2;
    build_order(3, 16, 4, 0);
    run_a(-1, u, 5, -1);
    checks++;
    if (en_cyc_q.size() != 36 || (en_cyc_q.size() > k && en_cyc_q[k] != u + 5)) begin
      failures++;
      $display("FAIL hold_en got count=%0d at=%0d want count=36 at=%0d",
               en_cyc_q.size(), en_cyc_q.size() > k ? en_cyc_q[k] : -1, u + 5);
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 114) begin
      failures++;
      $display("FAIL hold_done got=%0d want=114", done_cyc_q.size() ? done_cyc_q[0] : -1);
    end
    for (int j = 0; j < 36; j++) begin
      checks++;
      if (mem[exp_q[j]] !== init_mem[exp_q[j]] + lr * dmem[exp_q[j]]) begin
        failures++;
        $display("FAIL hold_data addr=%0d got=%h want=%h", exp_q[j], mem[exp_q[j]],
                 init_mem[exp_q[j]] + lr * dmem[exp_q[j]]);
      end
    end
  endtask

  task automatic test_midstart;
    run_a(50, -100, 0, -1);
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 109 || we_addr_q.size() != 36) begin
      failures++;
      $display("FAIL midstart got done=%0d writes=%0d want done=109 writes=36",
               done_cyc_q.size() ? done_cyc_q[0] : -1, we_addr_q.size());
    end
  endtask

  task automatic test_reset_mid;
    build_order(3, 16, 4, 0);
    run_a(-1, -100, 0, 33);
    checks++;
    if (we_at_rst !== 1'b0) begin
      failures++;
      $display("FAIL rst_we_dropped got=%b want=0", we_at_rst);
    end
    checks++;
    if (snap !== 25'd0) begin
      failures++;
      $display("FAIL rst_outputs got=%h want=0", snap);
    end
    checks++;
    if (we_addr_q.size() != 10 || we_addr_q[9] != exp_q[9]) begin
      failures++;
      $display("FAIL rst_writes got count=%0d want 10", we_addr_q.size());
    end
    run_a(-1, -100, 0, -1);
    checks++;
    if (we_addr_q.size() == 0 || we_addr_q[0] != 32 || re_cyc_q[0] != 1) begin
      failures++;
      $display("FAIL rst_restart got addr=%0d re=%0d want addr=32 re=1",
               we_addr_q.size() ? we_addr_q[0] : -1, re_cyc_q.size() ? re_cyc_q[0] : -1);
    end
  endtask

  task automatic test_small;
    int c, wn, dc;
    int addrs[$], wcyc[$], ecyc[$];
    dc = -1;
    @(posedge clk); #1 start_b = 1'b1;
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (b_we) begin addrs.push_back(int'(b_addr)); wcyc.push_back(c); end
      if (b_en) ecyc.push_back(c);
      if (b_done && dc < 0) dc = c;
      if (dc >= 0 && c > dc) break;
      @(posedge clk); #1 start_b = 1'b0;
      c++;
    end
    start_b = 1'b0;
    build_order(1, 16, 4, 0);
    wn = addrs.size();
    checks++;
    if (wn != 4) begin
      failures++;
      $display("FAIL small_count got=%0d want=4", wn);
    end
    for (int k = 0; k < 4 && k < wn && k < ecyc.size(); k++) begin
      checks++;
      if (addrs[k] != exp_q[k] || wcyc[k] != 4 * k + 4 || ecyc[k] != 4 * k + 3) begin
        failures++;
        $display("FAIL small_bias%0d got addr=%0d en=%0d we=%0d want addr=%0d en=%0d we=%0d",
                 k, addrs[k], ecyc[k], wcyc[k], exp_q[k], 4*k+3, 4*k+4);
      end
    end
    checks++;
    if (dc != 17) begin
      failures++;
      $display("FAIL small_done got=%0d want=17", dc);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_hold();
    test_midstart();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
